// File: rtl/dot_prod_pkg.sv
// Shared types, default widths and the saturating-add helper for the dot-product engine.
// sat_add is only referenced when DOT_PROD_SAT_EN is defined.
package dot_prod_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int ACC_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dp_state_t;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               sat;
    } sat_res_t;

    // Adds two w-bit values (carried in 64-bit containers) and clamps to the signed w-bit range.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int w);
        sat_res_t r;
        logic signed [64:0] s;
        logic signed [64:0] mx;
        logic signed [64:0] mn;
        s  = 65'(a) + 65'(b);
        mx = (65'sd1 <<< (w - 1)) - 65'sd1;
        mn = -(65'sd1 <<< (w - 1));
        if (s > mx) begin
            r.sum = mx[63:0];
            r.sat = 1'b1;
        end else if (s < mn) begin
            r.sum = mn[63:0];
            r.sat = 1'b1;
        end else begin
            r.sum = s[63:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_prod_engine_counter.sv
// Loadable up-counter used as the vector address generator.
module dot_prod_engine_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [N-1:0] d,
    input  logic         en,
    output logic [N-1:0] q
);
    logic [N-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (ld) begin
            q_reg <= d;
        end else if (en) begin
            q_reg <= q_reg + N'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/dot_prod_engine.sv
// Dot-product sequencer and MAC: walks A/B memories, accumulates signed products, pulses done.
// Define DOT_PROD_SAT_EN for saturating accumulation with a sticky ovf flag (default: wrap, ovf=0).
module dot_prod_engine
    import dot_prod_pkg::*;
#(
    parameter int DATA_W = dot_prod_pkg::DATA_W,
    parameter int ADDR_W = dot_prod_pkg::ADDR_W,
    parameter int ACC_W  = dot_prod_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic [ACC_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic              ovf
);
    generate
        if (ACC_W < 2 * DATA_W || ACC_W > 63) begin : g_bad_acc_w
            $error("dot_prod_engine: ACC_W must be >= 2*DATA_W and <= 63");
        end
    endgenerate

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    dp_state_t                 state_reg;
    logic [ADDR_W-1:0]         last_addr_reg;
    logic                      rd_valid_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [ACC_W-1:0]   acc_next;
    logic [ACC_W-1:0]          result_reg;
    logic [ADDR_W:0]           len_eff;
    logic [ADDR_W:0]           len_m1;
    logic                      accept;
    logic                      is_last;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;

    assign len_eff = (len > MAX_LEN) ? MAX_LEN : len;
    assign len_m1  = len_eff - (ADDR_W + 1)'(1);
    assign accept  = (state_reg == IDLE) && start;
    assign is_last = (mem_addr == last_addr_reg);

    assign prod     = (2 * DATA_W)'($signed(a_rdata)) * (2 * DATA_W)'($signed(b_rdata));
    assign prod_ext = ACC_W'(prod);

`ifdef DOT_PROD_SAT_EN
    logic     ovf_reg;
    logic     add_sat;
    sat_res_t sum_res;

    always_comb begin
        sum_res  = sat_add(64'(acc_reg), 64'(prod_ext), ACC_W);
        acc_next = sum_res.sum[ACC_W-1:0];
        add_sat  = sum_res.sat;
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            ovf_reg <= 1'b0;
        end else if (rd_valid_reg && add_sat) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
`else
    assign acc_next = acc_reg + prod_ext;
    assign ovf      = 1'b0;
`endif

    dot_prod_engine_counter #(
        .N (ADDR_W)
    ) u_addr_cnt (
        .clk (clk),
        .rst (rst),
        .ld  (accept),
        .d   ('0),
        .en  ((state_reg == RUN) && !is_last),
        .q   (mem_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_addr_reg <= '0;
            rd_valid_reg  <= 1'b0;
            acc_reg       <= '0;
            result_reg    <= '0;
        end else begin
            rd_valid_reg <= (state_reg == RUN);
            if (rd_valid_reg) begin
                acc_reg <= acc_next;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg <= '0;
                        if (len_eff == '0) begin
                            result_reg <= '0;
                            state_reg  <= DONE;
                        end else begin
                            last_addr_reg <= len_m1[ADDR_W-1:0];
                            state_reg     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (is_last) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The final product lands this cycle; capture the finished sum so it is valid alongside done.
                    result_reg <= acc_next;
                    state_reg  <= DONE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign result = result_reg;
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);

endmodule
